// File: rtl/riu_rd_merge_pkg.sv
// riu_pkg: shared types and helpers for the RIU read-merge block.
//   state_e       - request tracker state (IDLE / WAIT)
//   RIU_*_MIN/MAX - legal parameter ranges
//   riu_width()   - clog2-based width, never less than 1
package riu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int RIU_NUM_CH_MIN  = 1;
    localparam int RIU_NUM_CH_MAX  = 16;
    localparam int RIU_DATA_W_MIN  = 1;
    localparam int RIU_DATA_W_MAX  = 32;
    localparam int RIU_TIMEOUT_MIN = 2;
    localparam int RIU_TIMEOUT_MAX = 65535;

    // Index/counter width for n values; a single value still needs 1 bit.
    function automatic int riu_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/riu_rd_merge_if.sv
// riu_rd_merge_if: RIU read-return bus between the master, the slices and
// the merge block.
//   master modport - RIU master + slice side (drives request and slice data)
//   slave  modport - merge block (consumes slice data, drives merged return)
interface riu_rd_merge_if
    import riu_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
);
    localparam int SRC_W = riu_width(NUM_CH);

    logic                     RIU_RD_REQ;
    logic [NUM_CH*DATA_W-1:0] RIU_RD_DATA_IN;
    logic [NUM_CH-1:0]        RIU_RD_VALID_IN;
    logic [DATA_W-1:0]        RIU_RD_DATA;
    logic                     RIU_RD_VALID;
    logic [SRC_W-1:0]         RIU_RD_SRC;
    logic                     RIU_RD_COLLISION;
    logic                     RIU_RD_TIMEOUT;
    logic                     RIU_RD_UNSOL;
    logic                     RIU_RD_BUSY;

    modport master (
        output RIU_RD_REQ, RIU_RD_DATA_IN, RIU_RD_VALID_IN,
        input  RIU_RD_DATA, RIU_RD_VALID, RIU_RD_SRC, RIU_RD_COLLISION,
               RIU_RD_TIMEOUT, RIU_RD_UNSOL, RIU_RD_BUSY
    );

    modport slave (
        input  RIU_RD_REQ, RIU_RD_DATA_IN, RIU_RD_VALID_IN,
        output RIU_RD_DATA, RIU_RD_VALID, RIU_RD_SRC, RIU_RD_COLLISION,
               RIU_RD_TIMEOUT, RIU_RD_UNSOL, RIU_RD_BUSY
    );
endinterface

// File: rtl/riu_rd_prio_enc.sv
// riu_rd_prio_enc: combinational lowest-set-bit encoder.
//   valid_i [NUM_CH] - request vector
//   idx_o   [SRC_W]  - index of lowest set bit, 0 when none set
//   any_o            - at least one bit set
module riu_rd_prio_enc
    import riu_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SRC_W  = riu_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid_i,
    output logic [SRC_W-1:0]  idx_o,
    output logic              any_o
);
    always_comb begin
        idx_o = '0;
        // Scan high to low so the lowest set bit is the last write.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (valid_i[k]) idx_o = SRC_W'(k);
        end
    end

    assign any_o = |valid_i;
endmodule

// File: rtl/riu_rd_merge.sv
// riu_rd_merge: registered merge of NUM_CH slice read returns into one RIU
// read return, with single-outstanding request tracking.
//   RIU_CLK - clock (rising edge)
//   RST     - asynchronous active-high reset
//   bus     - slave side of riu_rd_merge_if: request strobe and slice
//             data/valid in; merged data/valid/src, collision, timeout,
//             unsolicited pulses and busy out
module riu_rd_merge
    import riu_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          RIU_CLK,
    input  logic          RST,
    riu_rd_merge_if.slave bus
);
    localparam int SRC_W = riu_width(NUM_CH);
    localparam int CNT_W = riu_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [NUM_CH-1:0] vld;
    logic [DATA_W-1:0] data_or;
    logic [SRC_W-1:0]  src_idx;
    logic              any_vld;
    logic              multi_vld;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              expire;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic              coll_q, coll_d;
    logic              to_q, to_d;
    logic              unsol_q, unsol_d;

    assign vld = bus.RIU_RD_VALID_IN;

    // Masked OR tree: invalid slices contribute nothing.
    always_comb begin
        data_or = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (vld[k]) data_or = data_or | bus.RIU_RD_DATA_IN[k*DATA_W +: DATA_W];
        end
    end

    riu_rd_prio_enc #(.NUM_CH(NUM_CH), .SRC_W(SRC_W)) u_prio (
        .valid_i (vld),
        .idx_o   (src_idx),
        .any_o   (any_vld)
    );

    // Clearing the lowest set bit leaves something iff two or more are set.
    assign multi_vld = |(vld & (vld - NUM_CH'(1)));

    // State / counter register
    always_ff @(posedge RIU_CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a REQ seen during WAIT is deliberately ignored so the
    // original request keeps its deadline.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RIU_RD_REQ) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (any_vld) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    expire  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values. Expiry only happens with no valid present, so the
    // merged data/valid are already zero in that cycle.
    always_comb begin
        data_d  = data_or;
        valid_d = any_vld;
        src_d   = src_idx;
        coll_d  = multi_vld;
        to_d    = expire;
        unsol_d = any_vld && (state_q == IDLE);
    end

    always_ff @(posedge RIU_CLK or posedge RST) begin
        if (RST) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            coll_q  <= 1'b0;
            to_q    <= 1'b0;
            unsol_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            coll_q  <= coll_d;
            to_q    <= to_d;
            unsol_q <= unsol_d;
        end
    end

    assign bus.RIU_RD_DATA      = data_q;
    assign bus.RIU_RD_VALID     = valid_q;
    assign bus.RIU_RD_SRC       = src_q;
    assign bus.RIU_RD_COLLISION = coll_q;
    assign bus.RIU_RD_TIMEOUT   = to_q;
    assign bus.RIU_RD_UNSOL     = unsol_q;
    assign bus.RIU_RD_BUSY      = (state_q == WAIT);
endmodule

// File: tb/tb_riu_rd_merge.sv
// tb_riu_rd_merge: directed scenarios plus randomized traffic against a
// transaction-level model of the read merge and request tracker.
module tb_riu_rd_merge;
    import riu_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic RIU_CLK = 1'b0;
    logic RST;
    always #5 RIU_CLK = ~RIU_CLK;

    riu_rd_merge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    riu_rd_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .RIU_CLK (RIU_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: is a request outstanding, and how many WAIT
    // edges have elapsed since it was issued.
    bit outstanding;
    int age;
    logic [DATA_W-1:0] e_data;
    logic       e_valid, e_coll, e_to, e_unsol;
    logic [3:0] e_src;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        outstanding = 0; age = 0;
        e_data = '0; e_valid = 0; e_src = '0; e_coll = 0; e_to = 0; e_unsol = 0;
    endtask

    // Evaluated at the active edge using the inputs that edge samples.
    task automatic model_edge();
        logic [NUM_CH-1:0] v;
        bit found;
        v = bus.RIU_RD_VALID_IN;
        e_data = '0; e_src = '0; found = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k]) begin
                e_data |= bus.RIU_RD_DATA_IN[k*DATA_W +: DATA_W];
                if (!found) begin e_src = 4'(k); found = 1; end
            end
        end
        e_valid = (v != 0);
        e_coll  = ($countones(v) > 1);
        e_unsol = e_valid && !outstanding;
        e_to    = 0;
        if (!outstanding) begin
            if (bus.RIU_RD_REQ) begin outstanding = 1; age = 0; end
        end else begin
            age++;
            if (e_valid) outstanding = 0;
            else if (age == TIMEOUT) begin outstanding = 0; e_to = 1; end
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(bus.RIU_RD_VALID), 32'(e_valid));
        chk("data",  32'(bus.RIU_RD_DATA),  32'(e_data));
        chk("src",   32'(bus.RIU_RD_SRC),   32'(e_src));
        chk("coll",  32'(bus.RIU_RD_COLLISION), 32'(e_coll));
        chk("tmo",   32'(bus.RIU_RD_TIMEOUT),   32'(e_to));
        chk("unsol", 32'(bus.RIU_RD_UNSOL),     32'(e_unsol));
        chk("busy",  32'(bus.RIU_RD_BUSY),      32'(outstanding));
    endtask

    task automatic step();
        @(posedge RIU_CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic req, input logic [NUM_CH-1:0] v,
                         input logic [NUM_CH*DATA_W-1:0] d);
        bus.RIU_RD_REQ      = req;
        bus.RIU_RD_VALID_IN = v;
        bus.RIU_RD_DATA_IN  = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [NUM_CH*DATA_W-1:0] d;

    initial begin
        RST = 1'b1;
        drive(1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge RIU_CLK);
        #1;
        check_all();
        RST = 1'b0;

        // Reset in the middle of WAIT aborts quietly
        drive(1'b1, '0, '0); step();
        idle(5);
        chk("rst_busy_pre", 32'(bus.RIU_RD_BUSY), 32'd1);
        #2 RST = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge RIU_CLK);
        #1 RST = 1'b0;
        idle(TIMEOUT + 5);
        chk("rst_no_tmo", 32'(bus.RIU_RD_TIMEOUT), 32'd0);

        // Normal read: slice 2 answers on WAIT edge 3
        drive(1'b1, '0, '0); step();
        idle(2);
        d = '0; d[2*DATA_W +: DATA_W] = 16'h1234;
        drive(1'b0, 4'b0100, d); step();
        chk("norm_valid", 32'(bus.RIU_RD_VALID), 32'd1);
        chk("norm_data",  32'(bus.RIU_RD_DATA),  32'h1234);
        chk("norm_src",   32'(bus.RIU_RD_SRC),   32'd2);
        chk("norm_busy",  32'(bus.RIU_RD_BUSY),  32'd0);
        idle(1);

        // Masking and collision
        drive(1'b1, '0, '0); step();
        d = {16'h0F00, 16'hABCD, 16'h00F0, 16'hFFFF};
        drive(1'b0, 4'b1010, d); step();
        chk("coll_data", 32'(bus.RIU_RD_DATA),      32'h0FF0);
        chk("coll_src",  32'(bus.RIU_RD_SRC),       32'd1);
        chk("coll_flag", 32'(bus.RIU_RD_COLLISION), 32'd1);
        idle(1);
        chk("coll_pulse", 32'(bus.RIU_RD_COLLISION), 32'd0);

        // Timeout run 1: nothing returns
        drive(1'b1, '0, '0); step();
        idle(TIMEOUT - 1);
        chk("to1_early", 32'(bus.RIU_RD_TIMEOUT), 32'd0);
        idle(1);
        chk("to1_fire",  32'(bus.RIU_RD_TIMEOUT), 32'd1);
        chk("to1_valid", 32'(bus.RIU_RD_VALID),   32'd0);
        chk("to1_data",  32'(bus.RIU_RD_DATA),    32'd0);
        chk("to1_busy",  32'(bus.RIU_RD_BUSY),    32'd0);
        idle(1);
        chk("to1_pulse", 32'(bus.RIU_RD_TIMEOUT), 32'd0);

        // Timeout run 2: valid on the last WAIT edge wins
        drive(1'b1, '0, '0); step();
        idle(TIMEOUT - 1);
        d = '0; d[DATA_W-1:0] = 16'hAAAA;
        drive(1'b0, 4'b0001, d); step();
        chk("to2_valid", 32'(bus.RIU_RD_VALID),   32'd1);
        chk("to2_tmo",   32'(bus.RIU_RD_TIMEOUT), 32'd0);
        idle(2);

        // Unsolicited response, then unsolicited + REQ together
        d = '0; d[DATA_W-1:0] = 16'h5A5A;
        drive(1'b0, 4'b0001, d); step();
        chk("unsol_flag",  32'(bus.RIU_RD_UNSOL), 32'd1);
        chk("unsol_valid", 32'(bus.RIU_RD_VALID), 32'd1);
        chk("unsol_busy",  32'(bus.RIU_RD_BUSY),  32'd0);
        drive(1'b1, 4'b0001, d); step();
        chk("unsolreq_flag", 32'(bus.RIU_RD_UNSOL), 32'd1);
        chk("unsolreq_busy", 32'(bus.RIU_RD_BUSY),  32'd1);
        idle(TIMEOUT + 1);

        // Repeated REQ in WAIT does not restart the deadline
        drive(1'b1, '0, '0); step();
        idle(3);
        drive(1'b1, '0, '0); step();
        idle(TIMEOUT - 5);
        chk("rreq_early", 32'(bus.RIU_RD_TIMEOUT), 32'd0);
        idle(1);
        chk("rreq_fire", 32'(bus.RIU_RD_TIMEOUT), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("rreq_late", 32'(bus.RIU_RD_TIMEOUT), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_CH-1:0] v;
            for (int k = 0; k < NUM_CH; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            v = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
            drive(($urandom_range(0, 4) == 0), v, d);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
